// File: rtl/spi_ep_pkg.sv
// Shared widths, the idle endpoint code and the select-FSM state type for the SPI endpoint slave.
package spi_ep_pkg;
    localparam int EP_W   = 8;
    localparam int BYTE_W = 8;
    localparam logic [EP_W-1:0] EP_NONE = 8'd0;

    typedef enum logic {
        SEL_IDLE,
        SEL_ACTIVE
    } sel_state_e;
endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchroniser for sclk/mosi/csel with sclk edge pulses on the synchronised clock.
// Latency: SYNC_STAGES cycles; the edge pulses are valid in the cycle the new level emerges.
module spi_pin_sync
    import spi_ep_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sclk_i,
    input  logic            mosi_i,
    input  logic [EP_W-1:0] csel_i,
    output logic            sclk_rise_o,
    output logic            sclk_fall_o,
    output logic            mosi_o,
    output logic [EP_W-1:0] csel_o
);
    logic [SYNC_STAGES-1:0]           sclk_q;
    logic [SYNC_STAGES-1:0]           mosi_q;
    logic [SYNC_STAGES-1:0][EP_W-1:0] csel_q;
    logic                             sclk_prev_q;

    // Idle values on reset so that no spurious edge or selection appears afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q      <= '1;
            mosi_q      <= '0;
            csel_q      <= '0;
            sclk_prev_q <= 1'b1;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            csel_q      <= {csel_q[SYNC_STAGES-2:0], csel_i};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_o =  sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] &  sclk_prev_q;
    assign mosi_o      = mosi_q[SYNC_STAGES-1];
    assign csel_o      = csel_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_ep_slave.sv
// SPI mode-3 slave turning the pins into an endpoint-tagged byte stream; no backpressure.
// rx_valid / spi_miso follow their sclk pin edge by SYNC_STAGES+1 clk cycles.
module spi_ep_slave
    import spi_ep_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CSEL_STABLE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [EP_W-1:0]   spi_csel,
    output logic [EP_W-1:0]   ep_sel,
    output logic              ep_start,
    output logic              ep_stop,
    output logic              rx_valid,
    output logic [BYTE_W-1:0] rx_data,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_load
);
    localparam int STAB_W = $clog2(CSEL_STABLE + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(CSEL_STABLE);
    localparam int BCNT_W = $clog2(BYTE_W);
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(BYTE_W - 1);

    logic            sclk_rise;
    logic            sclk_fall;
    logic            mosi_s;
    logic [EP_W-1:0] csel_s;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk         (clk),
        .reset       (reset),
        .sclk_i      (spi_sclk),
        .mosi_i      (spi_mosi),
        .csel_i      (spi_csel),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .mosi_o      (mosi_s),
        .csel_o      (csel_s)
    );

    sel_state_e        state_q;
    logic [EP_W-1:0]   ep_sel_q;
    logic [EP_W-1:0]   csel_prev_q;
    logic [STAB_W-1:0] stab_cnt_q;
    logic [STAB_W-1:0] stab_cnt_d;
    logic [BCNT_W-1:0] bit_cnt_q;
    logic [BYTE_W-1:0] rx_sr_q;
    logic [BYTE_W-1:0] tx_sr_q;
    logic [BYTE_W-1:0] rx_data_q;
    logic              ep_start_q;
    logic              ep_stop_q;
    logic              rx_valid_q;
    logic              tx_load_q;
    logic              miso_q;
    logic              take;

    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (csel_s != csel_prev_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    // csel_prev_q is the filtered value: it has held for CSEL_STABLE cycles when the counter saturates.
    assign take = (stab_cnt_q == STAB_MAX) && (csel_prev_q != ep_sel_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEL_IDLE;
            ep_sel_q    <= EP_NONE;
            csel_prev_q <= EP_NONE;
            stab_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rx_data_q   <= '0;
            ep_start_q  <= 1'b0;
            ep_stop_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            ep_start_q  <= 1'b0;
            ep_stop_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            csel_prev_q <= csel_s;
            stab_cnt_q  <= stab_cnt_d;
            case (state_q)
                SEL_IDLE: begin
                    miso_q <= 1'b0;
                    if (take) begin
                        ep_sel_q  <= csel_prev_q;
                        bit_cnt_q <= '0;
                        if (csel_prev_q != EP_NONE) begin
                            ep_start_q <= 1'b1;
                            state_q    <= SEL_ACTIVE;
                        end
                    end
                end
                SEL_ACTIVE: begin
                    // A switch to another endpoint keeps the old ep_sel here; IDLE picks up the new one next cycle.
                    if (take) begin
                        ep_stop_q <= 1'b1;
                        miso_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= SEL_IDLE;
                        if (csel_prev_q == EP_NONE) begin
                            ep_sel_q <= EP_NONE;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt_q == '0) begin
                            tx_sr_q   <= tx_data;
                            tx_load_q <= 1'b1;
                            miso_q    <= tx_data[BYTE_W-1];
                        end else begin
                            tx_sr_q <= {tx_sr_q[BYTE_W-2:0], 1'b0};
                            miso_q  <= tx_sr_q[BYTE_W-2];
                        end
                    end else if (sclk_rise) begin
                        rx_sr_q   <= {rx_sr_q[BYTE_W-2:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            rx_data_q  <= {rx_sr_q[BYTE_W-2:0], mosi_s};
                            rx_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= SEL_IDLE;
            endcase
        end
    end

    assign spi_miso = miso_q;
    assign ep_sel   = ep_sel_q;
    assign ep_start = ep_start_q;
    assign ep_stop  = ep_stop_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign tx_load  = tx_load_q;
endmodule

// File: doc/spi_ep_slave.md
Name: spi_ep_slave

Overview:
- SPI slave front end of the chip: mode 3 (CPOL=1, CPHA=1), oversampled in the `clk` domain.
- Converts the `spi_sclk`/`spi_mosi`/`spi_miso`/`spi_csel` pins into a byte stream tagged with an endpoint number.
- Directly upstream of the endpoint blocks (echo endpoint, PWM config endpoints).
- `spi_csel` is an 8-bit endpoint number; value 0 means no endpoint is selected.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the pin synchronisers (min 2).
- CSEL_STABLE, 3, cycles a new `spi_csel` value must hold unchanged before it is accepted (glitch filter for non-atomic 8-bit changes).

Ports:
- clk  in  1  system clock (12.3 MHz nominal)
- reset  in  1  synchronous, active-high reset
- spi_sclk  in  1  SPI clock pin, idles high
- spi_mosi  in  1  master-out data pin
- spi_miso  out  1  slave-out data pin, registered
- spi_csel  in  8  endpoint select pin bus; 0 = idle
- ep_sel  out  8  accepted endpoint number; 0 = none
- ep_start  out  1  one-cycle pulse when `ep_sel` becomes non-zero
- ep_stop  out  1  one-cycle pulse when a non-zero `ep_sel` is released
- rx_valid  out  1  one-cycle pulse: `rx_data` holds a complete received byte
- rx_data  out  8  received byte, MSB first; held until the next `rx_valid`
- tx_data  in  8  next byte to send, supplied by the selected endpoint
- tx_load  out  1  one-cycle pulse: `tx_data` was latched this cycle

Behaviour:
- Reset (synchronous, active-high):
  - `spi_miso`=0, `ep_sel`=0, `ep_start`=0, `ep_stop`=0, `rx_valid`=0, `rx_data`=0, `tx_load`=0.
  - Bit counter = 0; synchronisers and filter are loaded with idle values (sclk=1, csel=0).
  - Reset mid-byte discards the partial byte; no pulses are emitted.
- Synchronisation: `spi_sclk`, `spi_mosi` and all 8 `spi_csel` bits pass through SYNC_STAGES flip-flops. Edges are detected on the synchronised sclk.
- Select filter:
  - The synchronised `spi_csel` is compared with its previous value; any difference restarts a stability counter.
  - When the value has held for CSEL_STABLE cycles and differs from `ep_sel`, the FSM takes it.
- Select FSM, states IDLE / ACTIVE:
  - IDLE, accepted value non-zero: set `ep_sel`, pulse `ep_start`, clear bit counter, go to ACTIVE.
  - ACTIVE, accepted value 0: pulse `ep_stop`, set `ep_sel`=0, go to IDLE.
  - ACTIVE, accepted value a different non-zero endpoint: pulse `ep_stop` this cycle (`ep_sel` still the old value); next cycle set `ep_sel`=new value and pulse `ep_start`.
  - Every transition discards any partial byte and clears the bit counter.
- Bit engine (ACTIVE only; sclk edges in IDLE are ignored and `spi_miso` is held 0):
  - Falling edge with bit counter = 0: latch `tx_data` into the tx shifter, pulse `tx_load`, drive `spi_miso`=`tx_data[7]`.
  - Falling edge with bit counter ≠ 0: shift the tx shifter left and drive the next bit.
  - Rising edge: shift synchronised mosi into the rx shifter; bit counter increments.
  - At count 8: counter wraps to 0, `rx_data` is updated, `rx_valid` pulses.
- Latency: `rx_valid` and `spi_miso` updates occur SYNC_STAGES+1 cycles after the corresponding pin edge. Requirement: sclk half period ≥ SYNC_STAGES+3 clk cycles.
- Endpoint contract:
  - After `ep_start`, `tx_data` must be valid before the first falling edge.
  - After `tx_load`, the endpoint may change `tx_data` to the next byte; it has one full byte time.
  - `rx_valid` for byte n always precedes `tx_load` for byte n+2.
- Simultaneous events:
  - A select change in the same cycle as an sclk edge: the select FSM wins and the edge is dropped.
  - `rx_valid` and `ep_stop` never coincide for the same byte.

Decomposition:
- Package spi_ep_pkg holds:
  - EP_NONE = 8'd0
  - EP_W = 8
  - BYTE_W = 8
  - the select-FSM state enum
- One sub-module, spi_pin_sync: SYNC_STAGES synchroniser for sclk/mosi/csel plus sclk rise/fall pulse generation.

Test Plan:
1. Select EP 1 with `tx_data`=0x8F, master sends 0x77 (1000 ns sclk period) -> exactly one `rx_valid`, `rx_data`=0x77, `ep_sel`=1, master reads 0x8F, one `tx_load`.
2. 32 back-to-back bytes on EP 2 (values i*8+4, 10 ns word gap) -> 32 `rx_valid` pulses in order, 32 `tx_load` pulses, no bit slip.
3. Deselect after 5 sclk cycles of a byte -> no `rx_valid`, `ep_stop` pulses once; the next selection receives 0xA5 correctly aligned.
4. `spi_csel` 0 -> 3 passing through 0x01 for 1 clk cycle -> only `ep_start` with `ep_sel`=3; no pulse for EP 1.
5. Direct `spi_csel` change 1 -> 2 -> `ep_stop` (`ep_sel`=1), then `ep_start` with `ep_sel`=2 the next cycle.
6. Assert `reset` during bit 4 of a byte -> all outputs 0 the next cycle; after reselect, byte 0x3C is received intact.
